// File: rtl/console_number_printer.sv
// Converts one unsigned value to decimal (double-dabble) or uppercase hex ASCII and streams it to the console append bus.
// Latency: [1 clear] + VALUE_WIDTH (decimal) or 0 (hex) + 1 scan cycle to first char; start ignored while busy, no queueing.
module console_number_printer #(
  parameter int VALUE_WIDTH = 32,
  parameter int FIELD_WIDTH = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic                   hex_mode,
  input  logic                   clear_first,
  output logic [7:0]             append_char,
  output logic                   console_clear,
  output logic                   busy,
  output logic                   done
);

  // ceil(VALUE_WIDTH * log10(2)) in integer arithmetic
  localparam int BCD_DIGITS = (VALUE_WIDTH * 30103 + 99999) / 100000;
  localparam int HEX_DIGITS = (VALUE_WIDTH + 3) / 4;
  localparam int NDIG       = (BCD_DIGITS > HEX_DIGITS) ? BCD_DIGITS : HEX_DIGITS;
  localparam int DW         = NDIG * 4;
  localparam int CW         = $clog2(NDIG + 1);
  localparam int SW         = $clog2(VALUE_WIDTH);
  localparam int PW         = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CONVERT,
    S_SCAN,
    S_PAD,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                 state;
  logic [DW-1:0]          dig_q;
  logic [VALUE_WIDTH-1:0] sh_q;
  logic                   hex_q;
  logic [SW-1:0]          cnt_q;
  logic [CW-1:0]          idx_q;
  logic [PW-1:0]          pad_q;
  int                     n_scan;
  int                     pad_scan;

  function automatic logic [DW-1:0] dd_step(input logic [DW-1:0] d, input logic b);
    logic [DW-1:0] a;
    a = d;
    for (int i = 0; i < NDIG; i++) begin
      if (a[i*4 +: 4] >= 4'd5) a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
    end
    return {a[DW-2:0], b};
  endfunction

  function automatic logic [3:0] nib_at(input logic [DW-1:0] d, input int i);
    return d[i*4 +: 4];
  endfunction

  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Leading-zero suppression: highest nonzero digit sets the count, zero prints as one digit
  always_comb begin
    n_scan = 1;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_q[i*4 +: 4] != 4'd0) n_scan = i + 1;
    end
    pad_scan = (FIELD_WIDTH > n_scan) ? (FIELD_WIDTH - n_scan) : 0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      dig_q         <= '0;
      sh_q          <= '0;
      hex_q         <= 1'b0;
      cnt_q         <= '0;
      idx_q         <= '0;
      pad_q         <= '0;
      append_char   <= 8'h00;
      console_clear <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      console_clear <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          append_char <= 8'h00;
          if (start) begin
            hex_q <= hex_mode;
            sh_q  <= value;
            cnt_q <= '0;
            dig_q <= hex_mode ? DW'(value) : '0;
            busy  <= 1'b1;
            if (clear_first) begin
              console_clear <= 1'b1;
              state         <= S_CLEAR;
            end else begin
              state <= hex_mode ? S_SCAN : S_CONVERT;
            end
          end else begin
            state <= S_IDLE;
          end
        end

        S_CLEAR: state <= hex_q ? S_SCAN : S_CONVERT;

        S_CONVERT: begin
          dig_q <= dd_step(dig_q, sh_q[VALUE_WIDTH-1]);
          sh_q  <= sh_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SW'(VALUE_WIDTH - 1)) state <= S_SCAN;
        end

        // The scan edge already loads the first output character so there is no bubble
        S_SCAN: begin
          idx_q <= CW'(n_scan - 1);
          if (pad_scan > 0) begin
            append_char <= 8'h20;
            pad_q       <= PW'(pad_scan - 1);
            state       <= S_PAD;
          end else begin
            append_char <= to_ascii(nib_at(dig_q, n_scan - 1));
            state       <= S_EMIT;
          end
        end

        S_PAD: begin
          if (pad_q != '0) begin
            append_char <= 8'h20;
            pad_q       <= pad_q - 1'b1;
          end else begin
            append_char <= to_ascii(nib_at(dig_q, int'(idx_q)));
            state       <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (idx_q == '0) begin
            append_char <= 8'h00;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_DONE;
          end else begin
            idx_q       <= idx_q - 1'b1;
            append_char <= to_ascii(nib_at(dig_q, int'(idx_q) - 1));
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_console_number_printer.sv
// Directed bench for console_number_printer: two instances (no padding, FIELD_WIDTH=6) share stimulus.
module tb_console_number_printer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] value;
  logic        hex_mode;
  logic        clear_first;
  logic [7:0]  ac0, ac6;
  logic        cc0, cc6, busy0, busy6, done0, done6;

  always #5 clk = ~clk;

  console_number_printer #(.VALUE_WIDTH(32), .FIELD_WIDTH(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value), .hex_mode(hex_mode),
    .clear_first(clear_first), .append_char(ac0), .console_clear(cc0), .busy(busy0), .done(done0)
  );

  console_number_printer #(.VALUE_WIDTH(32), .FIELD_WIDTH(6)) u6 (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value), .hex_mode(hex_mode),
    .clear_first(clear_first), .append_char(ac6), .console_clear(cc6), .busy(busy6), .done(done6)
  );

  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] got [0:63];
  int   got_cyc [0:63];
  int   n_got, clr_cnt, clr_cyc, done_cyc;
  bit   contig;
  logic busy_at0, busy_at_done;

  function automatic string got_str();
    string s;
    s = "";
    for (int i = 0; i < n_got; i++) s = $sformatf("%s%c", s, got[i]);
    return s;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy0 && !busy6) break;
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [31:0] v, input bit hx, input bit clr);
    wait_idle();
    @(negedge clk);
    value = v; hex_mode = hx; clear_first = clr; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // k counts edges after the accepting edge; sample k is taken at the negedge after edge k
  task automatic collect(input bit sel, input int inj_k, input logic [31:0] inj_v,
                         input bit chain, input logic [31:0] chain_v);
    logic [7:0] a;
    logic c, b, d;
    n_got = 0; clr_cnt = 0; clr_cyc = -1; done_cyc = -1;
    busy_at0 = 1'b0; busy_at_done = 1'b1; got_cyc[0] = -1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      a = sel ? ac6 : ac0;
      c = sel ? cc6 : cc0;
      b = sel ? busy6 : busy0;
      d = sel ? done6 : done0;
      if (k == 0) busy_at0 = b;
      if (a != 8'h00 && n_got < 64) begin
        got[n_got] = a; got_cyc[n_got] = k; n_got++;
      end
      if (c) begin
        clr_cnt++;
        if (clr_cyc < 0) clr_cyc = k;
      end
      if (start) start = 1'b0;
      if (k == inj_k) begin
        start = 1'b1; value = inj_v;
      end
      if (d) begin
        done_cyc = k; busy_at_done = b;
        if (chain) begin
          value = chain_v; hex_mode = 1'b0; clear_first = 1'b0; start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
        break;
      end
    end
    contig = 1'b1;
    for (int i = 1; i < n_got; i++) if (got_cyc[i] != got_cyc[i-1] + 1) contig = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    #2;
    n_vec++;
    if ({ac0, cc0, busy0, done0, ac6, cc6, busy6, done6} !== 22'h0) begin
      n_err++; $display("FAIL reset_state: got %h want 0", {ac0, cc0, busy0, done0, ac6, cc6, busy6, done6});
    end
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({ac0, cc0, busy0, done0, ac6, cc6, busy6, done6} !== 22'h0) bad++;
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL idle_quiet: %0d noisy cycles, want 0", bad); end
  endtask

  task automatic test_decimal();
    issue(32'd1234, 1'b0, 1'b0);
    collect(1'b0, -1, 32'd0, 1'b0, 32'd0);
    n_vec++; if (got_str() != "1234") begin n_err++; $display("FAIL dec1234_chars: got '%s' want '1234'", got_str()); end
    n_vec++; if (got_cyc[0] !== 33) begin n_err++; $display("FAIL dec1234_latency: got %0d want 33", got_cyc[0]); end
    n_vec++; if (contig !== 1'b1) begin n_err++; $display("FAIL dec1234_contig: got %0d want 1", contig); end
    n_vec++; if (done_cyc !== 37) begin n_err++; $display("FAIL dec1234_done: got %0d want 37", done_cyc); end
    n_vec++; if (busy_at0 !== 1'b1 || busy_at_done !== 1'b0) begin
      n_err++; $display("FAIL dec1234_busy: got %b/%b want 1/0", busy_at0, busy_at_done);
    end
    n_vec++; if (clr_cnt !== 0) begin n_err++; $display("FAIL dec1234_noclear: got %0d want 0", clr_cnt); end

    issue(32'd0, 1'b0, 1'b0);
    collect(1'b0, -1, 32'd0, 1'b0, 32'd0);
    n_vec++; if (got_str() != "0") begin n_err++; $display("FAIL dec0_chars: got '%s' want '0'", got_str()); end
    n_vec++; if (got_cyc[0] !== 33 || done_cyc !== 34) begin
      n_err++; $display("FAIL dec0_timing: got %0d/%0d want 33/34", got_cyc[0], done_cyc);
    end

    issue(32'hFFFF_FFFF, 1'b0, 1'b0);
    collect(1'b0, -1, 32'd0, 1'b0, 32'd0);
    n_vec++; if (got_str() != "4294967295") begin n_err++; $display("FAIL decmax_chars: got '%s' want '4294967295'", got_str()); end
    n_vec++; if (done_cyc !== 43) begin n_err++; $display("FAIL decmax_done: got %0d want 43", done_cyc); end
  endtask

  task automatic test_hex_clear();
    issue(32'hDEAD_BEEF, 1'b1, 1'b1);
    collect(1'b0, -1, 32'd0, 1'b0, 32'd0);
    n_vec++; if (clr_cnt !== 1 || clr_cyc !== 0) begin
      n_err++; $display("FAIL hex_clear: got count %0d at %0d want 1 at 0", clr_cnt, clr_cyc);
    end
    n_vec++; if (got_str() != "DEADBEEF") begin n_err++; $display("FAIL hex_chars: got '%s' want 'DEADBEEF'", got_str()); end
    n_vec++; if (got_cyc[0] !== 2 || done_cyc !== 10) begin
      n_err++; $display("FAIL hex_timing: got %0d/%0d want 2/10", got_cyc[0], done_cyc);
    end

    issue(32'd7, 1'b0, 1'b1);
    collect(1'b0, -1, 32'd0, 1'b0, 32'd0);
    n_vec++; if (got_str() != "7" || got_cyc[0] !== 34 || clr_cyc !== 0) begin
      n_err++; $display("FAIL dec_clear: got '%s' at %0d clear %0d want '7' at 34 clear 0", got_str(), got_cyc[0], clr_cyc);
    end
  endtask

  task automatic test_padding();
    issue(32'd42, 1'b0, 1'b0);
    collect(1'b1, -1, 32'd0, 1'b0, 32'd0);
    n_vec++; if (got_str() != "    42") begin n_err++; $display("FAIL pad42_chars: got '%s' want '    42'", got_str()); end
    n_vec++; if (got_cyc[0] !== 33 || contig !== 1'b1 || done_cyc !== 39) begin
      n_err++; $display("FAIL pad42_timing: got %0d/%0d/%0d want 33/1/39", got_cyc[0], contig, done_cyc);
    end

    issue(32'd1234567, 1'b0, 1'b0);
    collect(1'b1, -1, 32'd0, 1'b0, 32'd0);
    n_vec++; if (got_str() != "1234567") begin n_err++; $display("FAIL pad_overflow: got '%s' want '1234567'", got_str()); end
    n_vec++; if (done_cyc !== 40) begin n_err++; $display("FAIL pad_overflow_done: got %0d want 40", done_cyc); end
  endtask

  task automatic test_busy_ignore();
    issue(32'd1234, 1'b0, 1'b0);
    collect(1'b0, 10, 32'd999, 1'b0, 32'd0);
    n_vec++; if (got_str() != "1234" || done_cyc !== 37) begin
      n_err++; $display("FAIL busy_ignore: got '%s' done %0d want '1234' done 37", got_str(), done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    issue(32'd1234, 1'b0, 1'b0);
    collect(1'b0, -1, 32'd0, 1'b1, 32'd77);
    n_vec++; if (got_str() != "1234") begin n_err++; $display("FAIL b2b_first: got '%s' want '1234'", got_str()); end
    collect(1'b0, -1, 32'd0, 1'b0, 32'd0);
    n_vec++; if (got_str() != "77" || got_cyc[0] !== 33 || done_cyc !== 35) begin
      n_err++; $display("FAIL b2b_second: got '%s' at %0d done %0d want '77' at 33 done 35", got_str(), got_cyc[0], done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    issue(32'hFFFF_FFFF, 1'b0, 1'b0);
    for (int k = 0; k <= 35; k++) @(negedge clk);
    n_vec++; if (ac0 !== 8'h39) begin n_err++; $display("FAIL mid_char: got %h want 39", ac0); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (ac0 !== 8'h00 || busy0 !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got char %h busy %b want 00/0", ac0, busy0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ac0 !== 8'h00 || ac6 !== 8'h00 || busy0 !== 1'b0 || busy6 !== 1'b0 || done0 !== 1'b0) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL post_reset_quiet: %0d noisy cycles, want 0", bad); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; value = '0; hex_mode = 1'b0; clear_first = 1'b0;
    test_reset();
    test_decimal();
    test_hex_clear();
    test_padding();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/console_number_printer.md
Name: console_number_printer

Overview:
- Upstream feeder for the on-screen text console.
- Takes one unsigned binary value per request and converts it to decimal (double-dabble) or uppercase hexadecimal.
- Emits the resulting ASCII characters one per clock on a character-append bus. A zero character means "no write".
- Used to print Mandelbrot parameters (zoom, iteration count, coordinates) into the console text buffer; optionally clears the console first.

Parameters:
- VALUE_WIDTH, 32: width of the input value; legal range 4..32.
- FIELD_WIDTH, 0: minimum printed width, left-padded with spaces; 0 disables padding; legal range 0..16.

Ports:
- clk  in  1  single clock; also drives the console write side.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only when busy=0.
- value  in  VALUE_WIDTH  unsigned value to print; captured on the accepted start.
- hex_mode  in  1  0 = decimal, 1 = hexadecimal; captured with value.
- clear_first  in  1  1 = clear the console before printing; captured with value.
- append_char  out  8  ASCII character to append; 8'h00 when no write.
- console_clear  out  1  one-cycle clear strobe to the console.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last character.

Behaviour:
- Reset (asynchronous, immediate): append_char=0, console_clear=0, busy=0, done=0, FSM=IDLE, all internal registers cleared. A reset mid-print truncates output immediately; no further characters are emitted.
- Character rules: all outputs are registered; append_char is nonzero for exactly one cycle per character.
- Digit encoding: decimal digits are 0x30..0x39; hex digits are 0x30..0x39 and 0x41..0x46; padding is 0x20.
- Start handling: start accepted when busy=0. value, hex_mode and clear_first are latched. start while busy=1 is ignored (no queueing).
- IDLE -> CLEAR if clear_first=1, else -> CONVERT. busy=1 from the next cycle.
- CLEAR: console_clear=1 for exactly one cycle, append_char=0. -> CONVERT.
- CONVERT:
  - Decimal: double-dabble over exactly VALUE_WIDTH cycles. Each cycle, add 3 to every BCD nibble >=5, then shift the value MSB into BCD.
  - BCD register holds ceil(VALUE_WIDTH*log10(2)) digits (10 for 32 bits).
  - Hex: 0 cycles; the nibbles are the value itself, ceil(VALUE_WIDTH/4) digits. -> SCAN.
- SCAN (1 cycle):
  - Priority-encode the first nonzero digit from the MSB to get digit count n.
  - value=0 gives n=1 (a single '0').
  - pad = FIELD_WIDTH-n if FIELD_WIDTH>n, else 0. -> PAD if pad>0, else EMIT.
- PAD: emit 0x20 for pad cycles. -> EMIT.
- EMIT: emit n digits, MSB first, one per cycle, with no gaps. -> DONE.
- DONE: done=1 for one cycle, busy=0 in that same cycle, append_char=0. -> IDLE.
- Back-to-back: a new start is accepted in the DONE cycle (busy=0).
- Total latency, decimal, from the accepted start edge to the first character: 1 (CLEAR, if used) + VALUE_WIDTH + 1 cycles.
- No truncation: if n exceeds FIELD_WIDTH, all n digits are emitted.
- Input stability: value and hex_mode changing during busy have no effect.

Test Plan:
- Reset, then hold start=0 for 20 cycles -> append_char=0, busy=0, done=0 and console_clear=0 throughout.
- value=32'd1234, hex_mode=0, clear_first=0, FIELD_WIDTH=0 -> after 33 cycles, 0x31,0x32,0x33,0x34 on consecutive cycles, then a done pulse. Same stimulus with value=0 -> single 0x30.
- value=32'hDEADBEEF, hex_mode=1, clear_first=1 -> console_clear for 1 cycle, then 44,45,41,44,42,45,45,46. value=32'hFFFFFFFF in decimal -> "4294967295".
- FIELD_WIDTH=6, value=42 decimal -> 0x20 x4 then 0x34,0x32. value=1234567 -> all 7 digits, no padding.
- Assert start again while busy with a different value -> ignored; only the first value is printed. Start in the DONE cycle -> accepted.
- Assert rst_n=0 midway through EMIT -> append_char=0 in the same cycle (asynchronous); after release, no residual characters and busy=0.
